// File: rtl/slip_timer_pkg.sv
// Shared register map, control bit positions and control register layout
// for the slip timer.
package slip_timer_pkg;

   localparam logic [1:0] ADDR_RLDL = 2'd0;
   localparam logic [1:0] ADDR_RLDH = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;
   localparam logic [1:0] ADDR_PSC  = 2'd3;

   localparam int CTL_EN   = 0;
   localparam int CTL_PER  = 1;
   localparam int CTL_IE   = 2;
   localparam int CTL_ACK  = 3;
   localparam int CTL_PEND = 3;

   // Field order matches the low nibble of a control register read.
   typedef struct packed {
      logic pend;
      logic ie;
      logic per;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/slip_timer_cnt.sv
// Loadable down counter with a zero flag; used for the main counter and,
// at 8 bits, for the optional prescaler.
module slip_timer_cnt
   import slip_timer_pkg::*;
#(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          cnt_en,
   output logic [CW-1:0] count,
   output logic          zero
);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (cnt_en)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/slip_timer_ctrl.sv
// CPU-programmable down-count timer with terminal-count pulse and interrupt.
// Define SLIP_TIMER_PRESCALE_EN to build in the 8-bit prescaler at A=3.
module slip_timer_ctrl
   import slip_timer_pkg::*;
#(
   parameter int CW = 16
) (
   input  logic       CLK,
   input  logic       RSTL,
   input  logic       WR,
   input  logic [1:0] A,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   output logic       TC,
   output logic       IRQ
);

   ctrl_t          ctrl;
   logic [CW-1:0]  rld;
   logic [CW-1:0]  cnt;
   logic [15:0]    cnt_ext;
   logic           cnt_zero;
   logic           ctrl_wr;
   logic           stop;
   logic           start;
   logic           active;
   logic           tick;
   logic           term;

   assign ctrl_wr = RSTL & WR & (A == ADDR_CTRL);
   assign stop    = ctrl_wr & ~DI[CTL_EN];
   assign start   = ctrl_wr &  DI[CTL_EN] & ~ctrl.en;
   // A stop write freezes the counter in the very cycle it is issued.
   assign active  = RSTL & ctrl.en & ~stop;

`ifdef SLIP_TIMER_PRESCALE_EN
   logic [7:0] psr;
   logic [7:0] psc;
   logic       psc_zero;

   slip_timer_cnt #(.CW(8)) u_psc (
      .clk      (CLK),
      .rst_n    (RSTL),
      .load     (start | term | (active & psc_zero)),
      .load_val (psr),
      .cnt_en   (active & ~psc_zero),
      .count    (psc),
      .zero     (psc_zero)
   );

   assign tick = active & psc_zero;
`else
   assign tick = active;
`endif

   assign term = tick & cnt_zero;

   slip_timer_cnt #(.CW(CW)) u_cnt (
      .clk      (CLK),
      .rst_n    (RSTL),
      .load     (start | (term & ctrl.per)),
      .load_val (rld),
      .cnt_en   (tick & ~cnt_zero),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RSTL) begin
         ctrl <= '0;
         rld  <= '0;
`ifdef SLIP_TIMER_PRESCALE_EN
         psr  <= '0;
`endif
      end else begin
         if (WR) begin
            case (A)
               ADDR_RLDL: rld[7:0]    <= DI;
               ADDR_RLDH: rld[CW-1:8] <= DI[CW-9:0];
               ADDR_CTRL: begin
                  ctrl.en  <= DI[CTL_EN];
                  ctrl.per <= DI[CTL_PER];
                  ctrl.ie  <= DI[CTL_IE];
               end
`ifdef SLIP_TIMER_PRESCALE_EN
               ADDR_PSC:  psr <= DI;
`endif
               default: ;
            endcase
         end
         // One-shot expiry overrides any simultaneous control write.
         if (term & ~ctrl.per)
            ctrl.en <= 1'b0;
         if (term)
            ctrl.pend <= 1'b1;
         else if (ctrl_wr & DI[CTL_ACK])
            ctrl.pend <= 1'b0;
      end
   end

   assign cnt_ext = 16'(cnt);

   always_comb begin
      DO = 8'h00;
      case (A)
         ADDR_RLDL: DO = cnt_ext[7:0];
         ADDR_RLDH: DO = cnt_ext[15:8];
         ADDR_CTRL: DO = {4'b0000, ctrl};
`ifdef SLIP_TIMER_PRESCALE_EN
         ADDR_PSC:  DO = psr;
`endif
         default:   DO = 8'h00;
      endcase
   end

   assign TC  = term;
   assign IRQ = RSTL & ctrl.pend & ctrl.ie;

endmodule

// File: tb/tb_slip_timer_ctrl.sv
// Scoreboard bench for slip_timer_ctrl (default build, prescaler absent):
// a reference model queues expected outputs, a negedge monitor compares.
module tb_slip_timer_ctrl;

   logic       CLK = 1'b0;
   logic       RSTL = 1'b0;
   logic       WR = 1'b0;
   logic [1:0] A = 2'd0;
   logic [7:0] DI = 8'h00;
   logic [7:0] DO;
   logic       TC;
   logic       IRQ;

   always #5 CLK = ~CLK;

   slip_timer_ctrl #(.CW(16)) dut (
      .CLK  (CLK),
      .RSTL (RSTL),
      .WR   (WR),
      .A    (A),
      .DI   (DI),
      .DO   (DO),
      .TC   (TC),
      .IRQ  (IRQ)
   );

   typedef struct {
      logic [1:0] a;
      logic [7:0] d;
      logic       tc;
      logic       irq;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   tc_seen = 0;

   // Reference state: the timer as seen from its register map.
   logic [15:0] m_cnt = '0;
   logic [15:0] m_rld = '0;
   bit          m_en = 0, m_per = 0, m_ie = 0, m_pend = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rstl, input bit wr, input bit [1:0] a, input bit [7:0] di);
      exp_t        e;
      bit          cw, stop_w, start_w, tick_w, tc_w, old_per;
      logic [15:0] old_rld;
      cw      = rstl && wr && (a == 2'd2);
      stop_w  = cw && !di[0];
      start_w = cw && di[0] && !m_en;
      tick_w  = rstl && m_en && !stop_w;
      tc_w    = tick_w && (m_cnt == 16'd0);
      e.a = a;
      case (a)
         2'd0:    e.d = m_cnt[7:0];
         2'd1:    e.d = m_cnt[15:8];
         2'd2:    e.d = {4'b0000, m_pend, m_ie, m_per, m_en};
         default: e.d = 8'h00;
      endcase
      e.tc  = tc_w;
      e.irq = rstl && m_pend && m_ie;
      sbq.push_back(e);
      if (!rstl) begin
         m_cnt = '0; m_rld = '0; m_en = 0; m_per = 0; m_ie = 0; m_pend = 0;
         return;
      end
      old_rld = m_rld;
      old_per = m_per;
      if (start_w)   m_cnt = old_rld;
      else if (tc_w) m_cnt = old_per ? old_rld : 16'd0;
      else if (tick_w) m_cnt = m_cnt - 16'd1;
      if (wr) begin
         case (a)
            2'd0: m_rld = {m_rld[15:8], di};
            2'd1: m_rld = {di, m_rld[7:0]};
            2'd2: begin m_en = di[0]; m_per = di[1]; m_ie = di[2]; end
            default: ;
         endcase
      end
      if (tc_w && !old_per) m_en = 0;
      if (tc_w) m_pend = 1;
      else if (cw && di[3]) m_pend = 0;
   endtask

   task automatic cycle(input bit rstl, input bit wr, input bit [1:0] a, input bit [7:0] di);
      @(posedge CLK);
      #1;
      RSTL = rstl; WR = wr; A = a; DI = di;
      model_step(rstl, wr, a, di);
   endtask

   task automatic settle();
      @(negedge CLK);
      #1;
   endtask

   task automatic idle(input int n, input bit [1:0] a);
      for (int i = 0; i < n; i++) cycle(1, 0, a, 8'h00);
   endtask

   // Monitor: every driven cycle presents one output set to compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("DO(A=%0d)", e.a), DO, e.d);
            check("TC", TC, e.tc);
            check("IRQ", IRQ, e.irq);
            if (TC === 1'b1) tc_seen++;
         end
      end
   end

   initial begin
      int tc0;
      bit [1:0] ra;
      bit [7:0] rd;
      bit rw, rr;

      // Bring the DUT out of its power-up X state before scoring starts.
      repeat (2) @(posedge CLK);

      for (int k = 0; k < 4; k++) cycle(0, 1, 2'(k), 8'hFF);

      // Periodic, RLD=3: TC every 4th tick, PEND afterwards.
      cycle(1, 1, 2'd0, 8'h03);
      cycle(1, 1, 2'd1, 8'h00);
      cycle(1, 1, 2'd2, 8'h03);
      settle(); tc0 = tc_seen;
      idle(16, 2'd0);
      settle();
      check("periodic_tc_count", tc_seen - tc0, 4);
      cycle(1, 0, 2'd2, 8'h00);
      settle();
      check("periodic_pend", DO[3], 1);
      cycle(1, 1, 2'd2, 8'h08);

      // One-shot, RLD=5: single TC on the sixth tick, IRQ until ACK.
      cycle(1, 1, 2'd0, 8'h05);
      cycle(1, 1, 2'd2, 8'h05);
      settle(); tc0 = tc_seen;
      idle(5, 2'd0);
      settle();
      check("oneshot_no_early_tc", tc_seen - tc0, 0);
      idle(1, 2'd0);
      settle();
      check("oneshot_tc_at_6", tc_seen - tc0, 1);
      idle(10, 2'd0);
      settle();
      check("oneshot_single_tc", tc_seen - tc0, 1);
      cycle(1, 0, 2'd2, 8'h00);
      settle();
      check("oneshot_en_clear", DO[0], 0);
      check("oneshot_irq", IRQ, 1);
      cycle(1, 1, 2'd2, 8'h0C);
      cycle(1, 0, 2'd2, 8'h00);
      settle();
      check("oneshot_irq_acked", IRQ, 0);

      // Zero reload: TC on every tick, then ACK colliding with TC.
      cycle(1, 1, 2'd0, 8'h00);
      cycle(1, 1, 2'd2, 8'h03);
      settle(); tc0 = tc_seen;
      idle(8, 2'd0);
      settle();
      check("zero_reload_tc_count", tc_seen - tc0, 8);
      cycle(1, 1, 2'd2, 8'h0B);
      cycle(1, 0, 2'd2, 8'h00);
      settle();
      check("ack_collision_pend", DO[3], 1);
      cycle(1, 1, 2'd2, 8'h08);

      // Reset mid-count from 0x1234, with a write that must be ignored.
      cycle(1, 1, 2'd0, 8'h34);
      cycle(1, 1, 2'd1, 8'h12);
      cycle(1, 1, 2'd2, 8'h05);
      idle(3, 2'd1);
      cycle(0, 1, 2'd2, 8'h0F);
      for (int k = 0; k < 3; k++) begin
         cycle(1, 0, 2'(k), 8'h00);
         settle();
         check($sformatf("post_reset_reg%0d", k), DO, 0);
      end

      // Prescaler register absent: write ignored, reads zero.
      cycle(1, 1, 2'd3, 8'h55);
      cycle(1, 0, 2'd3, 8'h00);
      settle();
      check("psr_absent", DO, 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         rr = ($urandom_range(199) != 0);
         rw = ($urandom_range(4) == 0);
         ra = 2'($urandom_range(3));
         rd = 8'($urandom);
         if (rw && ra == 2'd1) rd = 8'(rd % 2);
         if (rw && ra == 2'd2) rd[0] = ($urandom_range(7) != 0);
         cycle(rr, rw, ra, rd);
      end

      settle();
      check("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/slip_timer_ctrl.md
SLIP_TIMER_CTRL -- requirements
Module: slip_timer_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 16, meaning the down-counter width; legal range is 9..16.
REQ-002 The block SHALL have input CLK, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have input RSTL, 1 bit, a synchronous, active-low reset sampled on the rising edge of CLK.
REQ-004 The block SHALL have input WR, 1 bit, a CPU register write strobe, valid for one CLK cycle.
REQ-005 The block SHALL have input A, 2 bits, the register address.
REQ-006 The block SHALL have input DI, 8 bits, the write data.
REQ-007 The block SHALL have output DO, 8 bits, the combinational read data selected by A.
REQ-008 The block SHALL have output TC, 1 bit, a one-cycle terminal-count pulse.
REQ-009 The block SHALL have output IRQ, 1 bit, the level interrupt, equal to PEND AND IE.

Function
REQ-010 Register map SHALL be:
- A=0: reload low byte RLD[7:0]; read returns CNT[7:0].
- A=1: reload high byte RLD[CW-1:8]; read returns CNT[CW-1:8], zero-extended.
- A=2: control. Bit0 EN, bit1 PER, bit2 IE, bit3 ACK on write. Read returns {4'b0, PEND, IE, PER, EN}.
- A=3: prescaler; see Configuration.
REQ-011 Writing A=2 with EN=1 while EN=0 SHALL load CNT<=RLD on the next edge; no decrement or terminal check occurs that cycle.
REQ-012 A tick SHALL occur each cycle when EN=1 and no load occurs, qualified by the prescaler when it is compiled in.
REQ-013 On a tick with CNT!=0, CNT SHALL decrement by 1.
REQ-014 On a tick with CNT==0:
- TC pulses high for that cycle.
- PEND sets on the following edge.
- If PER=1, CNT reloads from RLD.
- If PER=0, EN clears and CNT holds at 0.
REQ-015 With RLD=N, the period SHALL be N+1 ticks. RLD=0 SHALL give TC on every tick.
REQ-016 Writes to RLD while EN=1 SHALL NOT alter CNT; the new value applies at the next reload or enable.
REQ-017 Writing A=2 with EN=0 SHALL stop counting immediately and hold CNT.
REQ-018 Writing A=2 with EN=1 while EN=1 SHALL update PER and IE only, with no reload.
REQ-019 ACK=1 in a control write SHALL clear PEND. If a terminal count occurs in the same cycle, the set SHALL win and PEND stays 1.
REQ-020 TC SHALL be combinational from the current state (EN, tick, CNT==0), with zero latency.

Reset
REQ-021 While RSTL=0 at a CLK edge, the following SHALL be cleared: CNT=0, RLD=0, EN=0, PER=0, IE=0, PEND=0, and the prescaler state.
REQ-022 TC=0 and IRQ=0 SHALL hold during and immediately after reset.
REQ-023 Reset asserted mid-count SHALL abort counting; no TC or PEND results.
REQ-024 A WR coincident with RSTL=0 SHALL be ignored.

Configuration
REQ-025 Macro SLIP_TIMER_PRESCALE_EN SHALL control the prescaler.
REQ-026 When SLIP_TIMER_PRESCALE_EN is defined:
- A=3 write sets PSR[7:0]; read returns PSR.
- An 8-bit prescale counter PSC loads PSR on enable and on each terminal event.
- PSC decrements every enabled cycle.
- A tick occurs only when PSC==0, giving a tick every PSR+1 cycles.
- PSC reloads from PSR when it reaches 0.
REQ-027 When SLIP_TIMER_PRESCALE_EN is undefined:
- A=3 writes are ignored and reads return 8'h00.
- A tick occurs every enabled, non-load cycle.

Structure
REQ-028 Package slip_timer_pkg SHALL hold:
- register address constants (ADDR_RLDL, ADDR_RLDH, ADDR_CTRL, ADDR_PSC);
- control bit-index constants (CTL_EN, CTL_PER, CTL_IE, CTL_ACK, CTL_PEND);
- a typedef for the control register struct.
REQ-029 Sub-module slip_timer_cnt SHALL implement the CW-bit loadable down counter. Its inputs are load, load data and count-enable; its outputs are count and the zero/borrow flag. It is reused for the prescaler with CW=8.

Verification
REQ-030 Periodic count: RLD=3, PER=1, EN=1 (no prescale) -> CNT runs 3,2,1,0,3,...; TC pulses every 4th cycle; PEND=1 after the first TC.
REQ-031 One-shot: RLD=5, PER=0, IE=1 -> exactly one TC, six ticks after load; EN reads 0 afterwards; IRQ=1 until ACK, then IRQ=0.
REQ-032 Zero reload: RLD=0, PER=1 -> TC high every tick; CNT stays 0.
REQ-033 Collision: write ACK in the same cycle as a TC -> PEND remains 1.
REQ-034 Reset mid-count: CNT=0x1234, RSTL=0 for one edge -> all registers 0; TC and IRQ remain 0.
REQ-035 With SLIP_TIMER_PRESCALE_EN: PSR=2, RLD=1, PER=1 -> TC every 6 cycles. Without the macro: A=3 reads 0x00 after a write of 0x55.
